// File: rtl/axis_l_sorter_pkg.sv
// axis_l_sorter_pkg: shared FSM states, word field widths, summary tag and default tuning constants
package axis_l_sorter_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, REARM} state_e;
  localparam int ID_W = 8;
  localparam int IDX_W = 24;
  localparam logic [ID_W-1:0] SUM_TAG = 8'hFF;
  localparam int FIFO_DEPTH = 4;
  localparam int DEF_THRESH = 200;
  localparam int DEF_WIN = 16;
  localparam int DEF_BIN1 = 400;
  localparam int DEF_BIN2 = 800;
  localparam int DEF_BIN3 = 1600;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: FIFO with up to two pushes per cycle and a registered head (dout/dvalid); free counts the head register
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       wr_n,
  input  logic [WIDTH-1:0] wr_d0,
  input  logic [WIDTH-1:0] wr_d1,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic [CW-1:0]    free
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic ov_q, ov_d, load;
  always_comb begin
    load = (cnt_q != '0) && (!ov_q || rd);
    mem_d = mem_q;
    if (wr_n != 2'd0) mem_d[wp_q] = wr_d0;
    if (wr_n == 2'd2) mem_d[wp_q + AW'(1)] = wr_d1;
    wp_d = wp_q + AW'(wr_n);
    rp_d = rp_q + AW'(load);
    cnt_d = cnt_q + CW'(wr_n) - CW'(load);
    out_d = load ? mem_q[rp_q] : out_q;
    ov_d = load || (ov_q && !rd);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ov_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ov_q <= ov_d;
    end
  end
  assign dout = out_q;
  assign dvalid = ov_q;
  assign free = CW'(DEPTH) - cnt_q - CW'(ov_q);
endmodule

// File: rtl/axis_l_sorter.sv
// axis_l_sorter: spike detector/classifier; s00 samples in, m00 event words {cluster,min_idx} and per-frame summary (tlast) out
module axis_l_sorter
  import axis_l_sorter_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int THRESH = DEF_THRESH,
  parameter int WIN = DEF_WIN,
  parameter int BIN1 = DEF_BIN1,
  parameter int BIN2 = DEF_BIN2,
  parameter int BIN3 = DEF_BIN3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast
);
  state_e state_q, state_d;
  logic signed [15:0] smp, min_q, min_d;
  logic [IDX_W-1:0] idx_q, idx_d, mi_q, mi_d, ev_cnt_q, ev_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0] st_n_q, st_n_d;
  logic [32:0] st_w0_q, st_w0_d, st_w1_q, st_w1_d, ev_w, sum_w, fifo_dout;
  logic hs, below, ev, fifo_vld;
  logic [16:0] mag;
  logic [ID_W-1:0] cid;
  logic [2:0] free;
  logic unused_bits;
  assign unused_bits = ^{s00_axis_tdata[C_AXIS_TDATA_WIDTH-1:16], s00_axis_tstrb};
  assign smp = s00_axis_tdata[15:0];
  assign below = int'(smp) < -THRESH;
  // Words still in the staging registers are not yet counted by the FIFO, so reserve them here.
  assign s00_axis_tready = !rst && ({1'b0, free} >= {2'b00, st_n_q} + 4'd2);
  always_comb begin
    hs = s00_axis_tvalid && s00_axis_tready;
    state_d = state_q;
    min_d = min_q;
    mi_d = mi_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    ev_cnt_d = ev_cnt_q;
    ev = 1'b0;
    if (hs) begin
      idx_d = idx_q + IDX_W'(1);
      case (state_q)
        IDLE: if (below) begin
          state_d = SEARCH;
          min_d = smp;
          mi_d = idx_q;
          cnt_d = 16'd1;
        end
        SEARCH: begin
          if (smp < min_q) begin
            min_d = smp;
            mi_d = idx_q;
          end
          cnt_d = cnt_q + 16'd1;
        end
        default: if (!below) state_d = IDLE;
      endcase
      ev = (state_d == SEARCH) && (cnt_d == 16'(WIN) || s00_axis_tlast);
      if (ev) state_d = REARM;
      ev_cnt_d = ev_cnt_q + IDX_W'(ev);
      if (s00_axis_tlast) begin
        idx_d = '0;
        ev_cnt_d = '0;
        state_d = IDLE;
      end
    end
    mag = -{min_d[15], min_d};
    cid = int'(mag) < BIN1 ? 8'd0 : int'(mag) < BIN2 ? 8'd1 : int'(mag) < BIN3 ? 8'd2 : 8'd3;
    ev_w = {1'b0, cid, mi_d};
    sum_w = {1'b1, SUM_TAG, ev_cnt_q + IDX_W'(ev)};
    st_n_d = {1'b0, ev} + {1'b0, hs && s00_axis_tlast};
    st_w0_d = ev ? ev_w : sum_w;
    st_w1_d = sum_w;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      min_q <= '0;
      mi_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      ev_cnt_q <= '0;
      st_n_q <= '0;
      st_w0_q <= '0;
      st_w1_q <= '0;
    end else begin
      state_q <= state_d;
      min_q <= min_d;
      mi_q <= mi_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      ev_cnt_q <= ev_cnt_d;
      st_n_q <= st_n_d;
      st_w0_q <= st_w0_d;
      st_w1_q <= st_w1_d;
    end
  end
  sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_n  (st_n_q),
    .wr_d0 (st_w0_q),
    .wr_d1 (st_w1_q),
    .rd    (m00_axis_tready),
    .dout  (fifo_dout),
    .dvalid(fifo_vld),
    .free  (free)
  );
  assign m00_axis_tdata = fifo_dout[31:0];
  assign m00_axis_tstrb = '1;
  assign m00_axis_tvalid = fifo_vld;
  assign m00_axis_tlast = fifo_vld && fifo_dout[32];
endmodule

// File: tb/tb_axis_l_sorter.sv
// tb_axis_l_sorter: scoreboard bench for axis_l_sorter
module tb_axis_l_sorter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0] s_tstrb = 4'hF;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic [3:0] m_tstrb;
  logic m_tvalid, m_tlast;
  logic m_tready = 1'b1;
  int n_chk = 0, n_fail = 0;
  logic [32:0] exp_q[$];
  always #5 clk = ~clk;
  axis_l_sorter dut (
    .clk(clk), .rst(rst),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready), .s00_axis_tlast(s_tlast),
    .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb), .m00_axis_tvalid(m_tvalid),
    .m00_axis_tready(m_tready), .m00_axis_tlast(m_tlast)
  );
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("unexpected_word", {m_tlast, m_tdata}, 33'h1_FFFF_FFFF ^ {m_tlast, m_tdata});
      else check("word", {m_tlast, m_tdata}, exp_q.pop_front());
    end
  task automatic send(input int v, input logic l);
    int n = 0;
    @(negedge clk);
    s_tdata = {16'hA5C3, 16'(v)};
    s_tvalid = 1'b1;
    s_tlast = l;
    while (!s_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) check("s_tready_timeout", 33'(s_tready), 33'd1);
  endtask
  task automatic idle;
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bv[9] = '{-200, -201, -399, -400, -799, -800, -1599, -1600, -32768};
    int bc[9] = '{-1, 0, 0, 1, 1, 2, 2, 3, 3};
    repeat (3) begin
      @(negedge clk);
      check("rst_s_tready", 33'(s_tready), 33'd0);
      check("rst_m_tvalid", 33'(m_tvalid), 33'd0);
      check("rst_m_tlast", 33'(m_tlast), 33'd0);
      check("rst_m_tdata", 33'(m_tdata), 33'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1 check("tready_after_rst", 33'(s_tready), 33'd1);
    check("m_tstrb", 33'(m_tstrb), 33'hF);
    exp_q.push_back(33'h1_FF00_0000);
    for (int i = 0; i < 10; i++) send(0, i == 9);
    @(posedge clk);
    idle;
    check("lat_e1", 33'(m_tvalid), 33'd0);
    @(negedge clk);
    check("lat_e2_pre", 33'(m_tvalid), 33'd0);
    @(negedge clk);
    check("lat_e2", 33'(m_tvalid), 33'd1);
    drain;
    exp_q.push_back(33'h0_0100_0006);
    exp_q.push_back(33'h1_FF00_0001);
    for (int i = 0; i < 30; i++) send(i == 5 ? -300 : i == 6 ? -500 : 0, i == 29);
    idle;
    drain;
    exp_q.push_back(33'h0_0300_0003);
    exp_q.push_back(33'h1_FF00_0001);
    for (int i = 0; i < 4; i++) send(i == 3 ? -2000 : 0, i == 3);
    idle;
    drain;
    exp_q.push_back(33'h0_0000_0000);
    exp_q.push_back(33'h1_FF00_0001);
    for (int i = 0; i < 41; i++) send(i < 40 ? -250 : 0, i == 40);
    idle;
    drain;
    for (int k = 0; k < 9; k++) begin
      if (bc[k] >= 0) exp_q.push_back({1'b0, 8'(bc[k]), 24'd0});
      exp_q.push_back({1'b1, 8'hFF, 24'(bc[k] >= 0 ? 1 : 0)});
      send(bv[k], 1'b1);
    end
    idle;
    drain;
    exp_q.push_back(33'h0_0100_0001);
    exp_q.push_back(33'h1_FF00_0001);
    send(0, 1'b0);
    send(-500, 1'b0);
    send(-500, 1'b0);
    send(-450, 1'b1);
    idle;
    drain;
    @(posedge clk);
    #1 m_tready = 1'b0;
    exp_q.push_back(33'h0_0000_0000);
    exp_q.push_back(33'h0_0000_0011);
    exp_q.push_back(33'h0_0000_0022);
    exp_q.push_back(33'h1_FF00_0003);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) send(0, 1'b0);
      send(-300, 1'b0);
      for (int i = 0; i < 15; i++) send(0, 1'b0);
      idle;
      check($sformatf("bp_tready_%0d", k), 33'(s_tready), 33'(k < 2));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 33'(m_tvalid), 33'd1);
      check("bp_hold_word", {m_tlast, m_tdata}, 33'h0_0000_0000);
      check("bp_tready_low", 33'(s_tready), 33'd0);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    send(0, 1'b1);
    idle;
    drain;
    send(-300, 1'b0);
    send(0, 1'b0);
    idle;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_s_tready", 33'(s_tready), 33'd0);
    check("rst2_m_tvalid", 33'(m_tvalid), 33'd0);
    rst = 1'b0;
    exp_q.push_back(33'h0_0100_0002);
    exp_q.push_back(33'h1_FF00_0001);
    send(0, 1'b0);
    send(0, 1'b0);
    send(-500, 1'b1);
    idle;
    drain;
    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_l_sorter.md
AXIS_L_SORTER -- requirements
Module: axis_l_sorter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- C_AXIS_TDATA_WIDTH, 32, stream width; only 32 is supported.
- THRESH, 200, detection threshold; a spike is detected when sample < -THRESH.
- WIN, 16, search window length in samples, counting the crossing sample.
- BIN1, 400, first peak-magnitude class boundary.
- BIN2, 800, second boundary.
- BIN3, 1600, third boundary.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock for both streams.
- rst, in, 1, synchronous, active-high reset.
- s00_axis_tdata, in, 32, bits [15:0] carry a signed 16-bit sample; bits [31:16] are ignored.
- s00_axis_tstrb, in, 4, ignored.
- s00_axis_tvalid, in, 1, input sample valid.
- s00_axis_tready, out, 1, block accepts a sample.
- s00_axis_tlast, in, 1, last sample of the frame.
- m00_axis_tdata, out, 32, result word.
- m00_axis_tstrb, out, 4, constant 4'hF.
- m00_axis_tvalid, out, 1, result valid.
- m00_axis_tready, in, 1, downstream accepts the result.
- m00_axis_tlast, out, 1, marks the frame summary word.

REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 A sample SHALL be consumed only on an s00 handshake (tvalid && tready); each consumed sample increments a 24-bit frame index that starts at 0 and wraps.
REQ-005 The detector FSM SHALL have three states:
- IDLE: a sample < -THRESH records min = sample and min_idx = index, sets cnt = 1, and moves to SEARCH.
- SEARCH: each sample with sample < min (strict; the earliest index wins ties) updates min and min_idx, and increments cnt.
- SEARCH exit: when cnt reaches WIN, the FSM emits an event and moves to REARM.
- REARM: stays until a sample >= -THRESH, then returns to IDLE. That sample itself is not evaluated for detection.
REQ-006 Event word format: [31:24] = cluster id, [23:0] = min_idx.
- Cluster id uses mag = -min: 0 if mag < BIN1, 1 if mag < BIN2, 2 if mag < BIN3, otherwise 3.
- Magnitude arithmetic SHALL be 17-bit, so that -32768 is handled.
REQ-007 A sample with tlast SHALL be processed normally first.
- If the FSM is in SEARCH after that sample, the event is emitted immediately, even if cnt < WIN.
- A summary word is then emitted: [31:24] = 8'hFF, [23:0] = number of events in the frame (wraps), with m00_axis_tlast = 1.
REQ-008 After a tlast sample, the frame index, event count and FSM SHALL return to 0 / IDLE.
REQ-009 Result words SHALL pass through a 4-entry FIFO with registered outputs, in order.
- A word produced by handshake edge E SHALL first be visible on m00 after edge E+2 when the FIFO is empty.
REQ-010 s00_axis_tready SHALL be 1 only when the FIFO has at least 2 free entries, so that an event and a summary from one sample never overflow it.
REQ-011 m00 data, valid and last SHALL hold stable while tvalid && !tready; a word leaves the FIFO only on an m00 handshake.
REQ-012 m00_axis_tlast SHALL be 1 only on summary words.

Reset
REQ-013 While rst = 1, the outputs SHALL be:
- s00_axis_tready = 0,
- m00_axis_tvalid = 0,
- m00_axis_tlast = 0,
- m00_axis_tdata = 0.
REQ-014 Reset SHALL clear the FIFO, FSM (IDLE), frame index and event count; a frame in progress is discarded without a summary.
REQ-015 s00_axis_tready SHALL rise on the first cycle after rst is deasserted.

Structure
REQ-016 A shared package SHALL hold:
- the FSM state enum (IDLE, SEARCH, REARM),
- the 8'hFF summary tag,
- the event/summary word field widths,
- the default THRESH, WIN and BIN constants.
REQ-017 The FIFO SHALL be one sub-module, sync_fifo (parameters width and depth, with a free-entry count output); the detector, classifier and counters SHALL live in axis_l_sorter.

Verification
REQ-018 Reset: hold rst for 3 cycles -> all outputs are 0 during reset; s00_axis_tready = 1 on the first cycle after release.
REQ-019 Frame of 10 zero samples, tlast on index 9, m00_axis_tready = 1 -> single word 0xFF000000 with tlast = 1.
REQ-020 30 samples, idx5 = -300, idx6 = -500, others 0, tlast on idx29 -> 0x01000006, then 0xFF000001 with tlast.
REQ-021 Sample idx3 = -2000 with tlast, others 0 -> 0x03000003, then 0xFF000001 with tlast (early close).
REQ-022 40 consecutive samples of -250, then 0, with tlast on idx40 -> exactly one event 0x00000000, then 0xFF000001.
REQ-023 Back-pressure: m00_axis_tready = 0 while 3 spikes are generated -> s00_axis_tready drops at 3 queued words; after release all words emerge in order with no loss or duplication.
